ao311_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single ao311 cell (z = a·b·c + d + e) among NREQ requesters. Each requester presents a 5-bit operand vector with a request. The block grants one requester at a time, evaluates its operands through the shared cell, and returns a registered result tagged with the requester ID over a valid/ready response channel. It sits between the lab's stimulus sources (switch banks, test sequencers) and the gate-level ao311 cell.

---
 rtl/ao311_pkg.sv | 28 ++
 rtl/ao311.sv | 24 ++
 rtl/ao311_arbiter_rr_pick.sv | 38 +++
 rtl/ao311_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ao311_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ao311_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ao311_pkg
// Description : Shared types and constants for the ao311 arbiter slice.
//               - state_t : arbiter FSM encoding (IDLE, EVAL, RESP)
//               - OPND_W  : width of one requester operand slice {a,b,c,d,e}
//               - *_POS   : bit position of each field inside a slice
// Revision    : 1.0 - initial release
// ============================================================================
package ao311_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned OPND_W = 5;

    // Operand slice layout: {a,b,c,d,e}, a in the MSB.
    localparam int unsigned A_POS = 4;
    localparam int unsigned B_POS = 3;
    localparam int unsigned C_POS = 2;
    localparam int unsigned D_POS = 1;
    localparam int unsigned E_POS = 0;

endpackage : ao311_pkg
`default_nettype wire

// File: rtl/ao311.sv
`default_nettype none
// ============================================================================
// Module      : ao311
// Description : AND-OR 3-1-1 cell, z = a&b&c | d | e.
// Ports       : a_i, b_i, c_i, d_i, e_i - cell inputs
//               z_o                     - cell output
// Revision    : 1.0 - initial release
// ============================================================================
module ao311 (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    input  logic d_i,
    input  logic e_i,
    output logic z_o
);

    logic w_and3;

    assign w_and3 = a_i & b_i & c_i;
    assign z_o    = w_and3 | d_i | e_i;

endmodule : ao311
`default_nettype wire

// File: rtl/ao311_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin winner selection. Scans req
//               starting at ptr and wrapping at NREQ-1 -> 0; the first set
//               bit wins.
// Ports       : req_i    - request vector, bit i = requester i
//               ptr_i    - highest-priority index
//               winner_o - index of the selected requester
//               any_o    - high when at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [IDW-1:0]  winner_o,
    output logic            any_o
);

    always_comb begin
        int unsigned idx;
        winner_o = '0;
        any_o    = 1'b0;
        idx      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_i) + i) % NREQ;
            if (!any_o && req_i[idx[IDW-1:0]]) begin
                any_o    = 1'b1;
                winner_o = idx[IDW-1:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/ao311_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ao311_arbiter
// Description : Round-robin sequencer sharing one ao311 cell among NREQ
//               requesters. A granted requester's operands are latched,
//               evaluated through the cell and returned as a registered,
//               ID-tagged result on a valid/ready channel.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               req, opnd         - request vector and packed operand slices
//               gnt               - one-cycle one-hot grant pulse
//               rsp_valid/ready   - response handshake
//               rsp_id, rsp_z     - answered requester and its result
//               busy              - FSM outside IDLE
//               chk_err           - sticky cell self-check error
// Options     : AO311_SELFCHECK_EN - compares the cell output against the
//               behavioural expression during EVAL; when undefined chk_err
//               is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module ao311_arbiter
    import ao311_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*OPND_W-1:0] opnd,
    output logic [NREQ-1:0]        gnt,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic                   rsp_z,
    output logic                   busy,
    output logic                   chk_err
);

    state_t              state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]      rsp_id_q, rsp_id_d;
    logic                rsp_z_q, rsp_z_d;
    logic [OPND_W-1:0]   opnd_q, opnd_d;

    logic [IDW-1:0]      w_winner;
    logic                w_any;
    logic                w_cell_z;
    logic [OPND_W-1:0]   w_slice [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign w_slice[gi] = opnd[gi*OPND_W +: OPND_W];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (w_winner),
        .any_o    (w_any)
    );

    ao311 u_cell (
        .a_i (opnd_q[A_POS]),
        .b_i (opnd_q[B_POS]),
        .c_i (opnd_q[C_POS]),
        .d_i (opnd_q[D_POS]),
        .e_i (opnd_q[E_POS]),
        .z_o (w_cell_z)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_z_d     = rsp_z_q;
        opnd_d      = opnd_q;
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    opnd_d   = w_slice[w_winner];
                    rsp_id_d = w_winner;
                    gnt_d    = NREQ'(1) << w_winner;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                rsp_z_d     = w_cell_z;
                gnt_d       = '0;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    // Next scan starts just past the requester we served.
                    ptr_d   = (rsp_id_q == IDW'(NREQ - 1)) ? '0 : rsp_id_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d       = '0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_z_q     <= 1'b0;
            opnd_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_z_q     <= rsp_z_d;
            opnd_q      <= opnd_d;
        end
    end

`ifdef AO311_SELFCHECK_EN
    logic chk_err_q, chk_err_d;
    logic w_expect_z;

    assign w_expect_z = (opnd_q[A_POS] & opnd_q[B_POS] & opnd_q[C_POS])
                      | opnd_q[D_POS] | opnd_q[E_POS];

    always_comb begin
        chk_err_d = chk_err_q;
        if ((state_q == EVAL) && (w_cell_z != w_expect_z)) begin
            chk_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err_q <= 1'b0;
        end else begin
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_z     = rsp_z_q;
    assign busy      = (state_q != IDLE);

endmodule : ao311_arbiter
`default_nettype wire

// File: tb/tb_ao311_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ao311_arbiter
// Description : Directed self-checking bench for ao311_arbiter (NREQ=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ao311_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*5-1:0] opnd;
    logic [NREQ-1:0]   gnt;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_z;
    logic              busy;
    logic              chk_err;

    int checks;
    int errors;

    ao311_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .opnd      (opnd),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .busy      (busy),
        .chk_err   (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ao311_ref(input logic [4:0] v);
        return (v[4] & v[3] & v[2]) | v[1] | v[0];
    endfunction

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req       = '0;
        opnd      = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // ---------------- reset state
        check("rst_gnt",   32'(gnt),       32'h0);
        check("rst_valid", 32'(rsp_valid), 32'h0);
        check("rst_id",    32'(rsp_id),    32'h0);
        check("rst_z",     32'(rsp_z),     32'h0);
        check("rst_busy",  32'(busy),      32'h0);
        check("rst_chk",   32'(chk_err),   32'h0);

        // ---------------- single request, z=1 (other slices all-ones)
        opnd           = '1;
        opnd[9:5]      = 5'b11100;
        req            = 4'b0010;
        rsp_ready      = 1'b1;
        tick();
        check("s1_gnt",  32'(gnt),  32'h2);
        check("s1_busy", 32'(busy), 32'h1);
        req = '0;
        tick();
        check("s1_valid", 32'(rsp_valid), 32'h1);
        check("s1_id",    32'(rsp_id),    32'h1);
        check("s1_z",     32'(rsp_z),     32'h1);
        check("s1_gnt0",  32'(gnt),       32'h0);
        tick();
        check("s1_done_valid", 32'(rsp_valid), 32'h0);
        check("s1_done_busy",  32'(busy),      32'h0);

        // ---------------- single request, z=0
        opnd[9:5] = 5'b11000;
        req       = 4'b0010;
        tick();
        check("s2_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick();
        check("s2_id", 32'(rsp_id), 32'h1);
        check("s2_z",  32'(rsp_z),  32'h0);
        tick();

        // ---------------- reset in RESP with rsp_ready low
        opnd[14:10] = 5'b00010;
        req         = 4'b0100;
        rsp_ready   = 1'b0;
        tick();
        req = '0;
        tick();
        check("mr_valid_pre", 32'(rsp_valid), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_gnt",   32'(gnt),       32'h0);
        check("mr_valid", 32'(rsp_valid), 32'h0);
        check("mr_id",    32'(rsp_id),    32'h0);
        check("mr_z",     32'(rsp_z),     32'h0);
        check("mr_busy",  32'(busy),      32'h0);

        // ---------------- contention: all requesting, ptr back at 0
        req       = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
            tick();
            check($sformatf("rr_id%0d", k), 32'(rsp_id), 32'(k % 4));
            check($sformatf("rr_gap%0d", k), 32'(gnt), 32'h0);
            tick();
        end
        req = '0;
        // ptr is now 1

        // ---------------- wrap: serve 2 (ptr->3), then 3 before 0
        req = 4'b0100;
        tick();
        check("wr_gnt2", 32'(gnt), 32'h4);
        req = '0;
        tick();
        tick();
        req = 4'b1001;
        tick();
        check("wr_gnt3", 32'(gnt), 32'h8);
        tick();
        check("wr_id3", 32'(rsp_id), 32'h3);
        tick();
        tick();
        check("wr_gnt0", 32'(gnt), 32'h1);
        req = '0;
        tick();
        check("wr_id0", 32'(rsp_id), 32'h0);
        tick();
        // ptr is now 1

        // ---------------- backpressure
        opnd[9:5] = 5'b11100;
        req       = 4'b0010;
        rsp_ready = 1'b0;
        tick();
        check("bp_gnt", 32'(gnt), 32'h2);
        req = '0;
        tick();
        opnd = '0;
        req  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_valid%0d", k), 32'(rsp_valid), 32'h1);
            check($sformatf("bp_id%0d", k),    32'(rsp_id),    32'h1);
            check($sformatf("bp_z%0d", k),     32'(rsp_z),     32'h1);
            check($sformatf("bp_busy%0d", k),  32'(busy),      32'h1);
            check($sformatf("bp_gnt%0d", k),   32'(gnt),       32'h0);
            tick();
        end
        req       = '0;
        rsp_ready = 1'b1;
        tick();
        check("bp_acc_valid", 32'(rsp_valid), 32'h0);
        check("bp_acc_busy",  32'(busy),      32'h0);

        // ---------------- exhaustive operands on requester 2
        for (int v = 0; v < 32; v++) begin
            logic [4:0] vv;
            vv          = 5'(v);
            opnd        = '1;
            opnd[14:10] = vv;
            req         = 4'b0100;
            tick();
            req  = '0;
            opnd = '0;
            tick();
            check($sformatf("ex_id_%0d", v), 32'(rsp_id), 32'h2);
            check($sformatf("ex_z_%0d", v),  32'(rsp_z),  32'(ao311_ref(vv)));
            tick();
        end
        check("ex_chk_err", 32'(chk_err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ao311_arbiter
`default_nettype wire
